// File: rtl/opcode_issue_encoder_pkg.sv
// Opcode classes, prefix constants and encode/legality helpers shared by the issue encoder.
// OPC_PARITY_EN widens stored entries to carry an odd-parity bit.
package opc_enc_pkg;

   localparam logic [1:0] CLS_A0   = 2'b00;
   localparam logic [1:0] CLS_A1   = 2'b01;
   localparam logic [1:0] CLS_MW   = 2'b10;
   localparam logic [1:0] CLS_WIDE = 2'b11;

   localparam logic [2:0] PFX_A0   = 3'b000;
   localparam logic [2:0] PFX_A1   = 3'b001;
   localparam logic [1:0] PFX_MW   = 2'b01;
   localparam logic       PFX_WIDE = 1'b1;

   // Only the memory-write class may (and must) carry the mem-write flag
   function automatic logic is_illegal(input logic [1:0] alu_op, input logic mw);
      return mw != (alu_op == CLS_MW);
   endfunction

   function automatic logic [3:0] encode_opc(input logic [1:0] alu_op, input logic mw,
                                             input logic [2:0] sub);
      logic [3:0] opc;
      opc = '0;
      if (!is_illegal(alu_op, mw)) begin
         case (alu_op)
            CLS_A0:   opc = {PFX_A0, sub[0]};
            CLS_A1:   opc = {PFX_A1, sub[0]};
            CLS_MW:   opc = {PFX_MW, sub[1:0]};
            default:  opc = {PFX_WIDE, sub[2:0]};
         endcase
      end
      return opc;
   endfunction

endpackage

// File: rtl/opcode_issue_encoder_fifo.sv
// opc_fifo: synchronous FIFO with flush; head is read straight from the storage registers,
// so a write never falls through to rd_data in the same cycle.
module opc_fifo #(
   parameter int unsigned      WIDTH   = 4,
   parameter int unsigned      DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push    = wr_en && !full && !flush;
   assign pop     = rd_ready && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/opcode_issue_encoder.sv
// Encodes sequencer requests into 4-bit opcodes, buffers them, flags illegal requests and
// counts issues. Define OPC_PARITY_EN to add the stored odd-parity output opc_par.
module opcode_issue_encoder
   import opc_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_alu_op,
   input  logic             req_mem_write,
   input  logic [2:0]       req_sub,
   input  logic             flush,
   output logic             opc_valid,
   input  logic             opc_ready,
   output logic [3:0]       opc,
`ifdef OPC_PARITY_EN
   output logic             opc_par,
`endif
   output logic             err_illegal,
   output logic [CNT_W-1:0] issued_cnt
);

`ifdef OPC_PARITY_EN
   localparam int unsigned         ENTRY_W   = 5;
   localparam logic [ENTRY_W-1:0] ENTRY_RST = 5'b1_0000;
`else
   localparam int unsigned         ENTRY_W   = 4;
   localparam logic [ENTRY_W-1:0] ENTRY_RST = 4'b0000;
`endif

   logic               illegal;
   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [3:0]         enc;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;

   assign illegal   = is_illegal(req_alu_op, req_mem_write);
   assign enc       = encode_opc(req_alu_op, req_mem_write, req_sub);
   assign req_ready = rst_n && !fifo_full && !flush;
   assign accept    = req_valid && req_ready;
   assign push      = accept && !illegal;
   assign opc_valid = !fifo_empty;
   assign pop       = opc_valid && opc_ready;

`ifdef OPC_PARITY_EN
   assign wr_entry = {~^enc, enc};
   assign opc      = head[3:0];
   assign opc_par  = head[4];
`else
   assign wr_entry = enc;
   assign opc      = head;
`endif

   opc_fifo #(
      .WIDTH   (ENTRY_W),
      .DEPTH   (DEPTH),
      .RST_VAL (ENTRY_RST)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en    (push),
      .wr_data  (wr_entry),
      .rd_ready (opc_ready),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .rd_data  (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_illegal <= 1'b0;
         issued_cnt  <= '0;
      end else begin
         err_illegal <= accept && illegal;
         if (pop) issued_cnt <= issued_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_opcode_issue_encoder.sv
// Bench for opcode_issue_encoder: directed table, hand sequences, random traffic against a
// queue-based reference model, and issue-counter wrap. Honours OPC_PARITY_EN.
module tb_opcode_issue_encoder;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_alu_op;
   logic             req_mem_write;
   logic [2:0]       req_sub;
   logic             flush;
   logic             opc_valid;
   logic             opc_ready;
   logic [3:0]       opc;
   logic             err_illegal;
   logic [CNT_W-1:0] issued_cnt;
`ifdef OPC_PARITY_EN
   logic             opc_par;
`endif

   opcode_issue_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_alu_op    (req_alu_op),
      .req_mem_write (req_mem_write),
      .req_sub       (req_sub),
      .flush         (flush),
      .opc_valid     (opc_valid),
      .opc_ready     (opc_ready),
      .opc           (opc),
`ifdef OPC_PARITY_EN
      .opc_par       (opc_par),
`endif
      .err_illegal   (err_illegal),
      .issued_cnt    (issued_cnt)
   );

   always #5 clk = ~clk;

   int unsigned      n_cmp = 0;
   int unsigned      n_err = 0;
   logic [3:0]       q[$];
   logic [CNT_W-1:0] m_cnt;
   logic             m_err;
   logic             last_ready;

   typedef struct {
      logic       v;
      logic [1:0] alu;
      logic       mw;
      logic [2:0] sub;
      logic       fl;
      logic       rdy;
      logic       exp_ready;
      logic       exp_valid;
      logic [3:0] exp_opc;
      logic       exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding as plain arithmetic on class and sub-op value
   function automatic logic [3:0] ref_enc(input logic [1:0] alu, input logic [2:0] sub);
      int s = int'(sub);
      case (alu)
         2'd0:    return 4'(s % 2);
         2'd1:    return 4'(2 + s % 2);
         2'd2:    return 4'(4 + s % 4);
         default: return 4'(8 + s);
      endcase
   endfunction

   task automatic check_outputs();
      check("opc_valid", opc_valid, q.size() > 0);
      if (q.size() > 0) begin
         check("opc", opc, q[0]);
`ifdef OPC_PARITY_EN
         check("opc_par", opc_par, ~^q[0]);
`endif
      end
      check("err_illegal", err_illegal, m_err);
      check("issued_cnt", issued_cnt, m_cnt);
   endtask

   // One clock: drive request, check req_ready, advance model at the edge, check outputs
   task automatic cyc(input logic v, input logic [1:0] alu, input logic mw,
                      input logic [2:0] sub, input logic fl, input logic rdy);
      logic m_ready, m_pop, m_acc, m_ill;
      req_valid = v; req_alu_op = alu; req_mem_write = mw; req_sub = sub;
      flush = fl; opc_ready = rdy;
      #1;
      m_ready    = (q.size() < DEPTH) && !fl;
      last_ready = req_ready;
      check("req_ready", req_ready, m_ready);
      @(posedge clk); #1;
      m_pop = (q.size() > 0) && rdy;
      m_acc = v && m_ready;
      m_ill = (alu == 2'd2) != mw;
      if (m_pop) m_cnt = m_cnt + 1'b1;
      if (fl) q.delete();
      else begin
         if (m_pop) void'(q.pop_front());
         if (m_acc && !m_ill) q.push_back(ref_enc(alu, sub));
      end
      m_err = m_acc && m_ill;
      check_outputs();
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b1, 2'b01, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 16'd0};
      tbl[1]  = '{1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd1};
      tbl[2]  = '{1'b1, 2'b11, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 16'd1};
      tbl[3]  = '{1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 16'd1};
      tbl[4]  = '{1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 16'd2};
      tbl[5]  = '{1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd3};
      tbl[6]  = '{1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd3};
      tbl[7]  = '{1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd3};
      tbl[8]  = '{1'b1, 2'b00, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 16'd3};
      tbl[9]  = '{1'b1, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd4};
      tbl[10] = '{1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd4};
      tbl[11] = '{1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd4};

      rst_n = 1'b0; req_valid = 1'b0; req_alu_op = '0; req_mem_write = 1'b0;
      req_sub = '0; flush = 1'b0; opc_ready = 1'b0;
      model_reset();
      #3;
      check("rst_opc_valid", opc_valid, 1'b0);
      check("rst_opc", opc, 4'b0000);
      check("rst_err", err_illegal, 1'b0);
      check("rst_cnt", issued_cnt, 16'd0);
      check("rst_req_ready", req_ready, 1'b0);
`ifdef OPC_PARITY_EN
      check("rst_opc_par", opc_par, 1'b1);
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].v, tbl[i].alu, tbl[i].mw, tbl[i].sub, tbl[i].fl, tbl[i].rdy);
         check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].exp_ready);
         check($sformatf("tbl%0d_valid", i), opc_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid) check($sformatf("tbl%0d_opc", i), opc, tbl[i].exp_opc);
         check($sformatf("tbl%0d_err", i), err_illegal, tbl[i].exp_err);
         check($sformatf("tbl%0d_cnt", i), issued_cnt, tbl[i].exp_cnt);
      end

      // Fill to full under backpressure, then pop+push at DEPTH-1
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 2'b11, 1'b0, 3'(i), 1'b0, 1'b0);
      cyc(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
      check("full_blocks_push", last_ready, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      cyc(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
      check("pop_push_accepted", last_ready, 1'b1);
      check("pop_push_head", opc, 4'b1010);
      cyc(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
      check("refill_accepted", last_ready, 1'b1);
      cyc(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
      check("occupancy_kept_full", last_ready, 1'b0);

      // Flush with 3 entries buffered and a request pending
      cyc(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      cyc(1'b1, 2'b01, 1'b0, 3'b001, 1'b1, 1'b0);
      check("flush_rejects_req", last_ready, 1'b0);
      check("flush_empties", opc_valid, 1'b0);
      check("flush_cnt_kept", issued_cnt, 16'd7);
      cyc(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      check("post_flush_empty", opc_valid, 1'b0);

      // Flush concurrent with a pop still counts the pop
      cyc(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1);
      check("flush_pop_counted", issued_cnt, 16'd8);

      // Asynchronous reset mid-operation
      cyc(1'b1, 2'b11, 1'b0, 3'b111, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_valid", opc_valid, 1'b0);
      check("midrst_err", err_illegal, 1'b0);
      check("midrst_cnt", issued_cnt, 16'd0);
      check("midrst_ready", req_ready, 1'b0);
      check("midrst_opc", opc, 4'b0000);
      @(posedge clk); #1 rst_n = 1'b1;

      // Randomised traffic, ~80% legal requests
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] alu;
         logic       mw;
         alu = 2'($urandom_range(0, 3));
         mw  = (alu == 2'b10);
         if ($urandom_range(0, 9) >= 8) mw = !mw;
         cyc($urandom_range(0, 9) < 7, alu, mw, 3'($urandom_range(0, 7)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
      end

      // Drive the issue counter up to all-ones, then wrap it
      for (int g = 0; g < 70000 && m_cnt != 16'hFFFF; g++)
         cyc(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 1'b1);
      check("cnt_at_ffff", issued_cnt, 16'hFFFF);
      check("wrap_head_valid", opc_valid, 1'b1);
      check("wrap_head_opc", opc, 4'b0110);
`ifdef OPC_PARITY_EN
      check("wrap_head_par", opc_par, 1'b1);
`endif
      cyc(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      check("cnt_wrapped", issued_cnt, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
